// File: rtl/pc_pipe_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pc_pipe_buffer
//  Description : Elastic pipeline buffer for PC/instruction words between CPU
//                stages. DEPTH register stages with per-stage valid bits,
//                valid/ready flow control, flush, and bubble collapsing.
//  Ports       : clk, rst (sync, active-high), flush
//                in_valid/in_data/in_ready    - upstream handshake
//                out_valid/out_data/out_ready - downstream handshake
//                occupancy                    - number of valid stages
//  Revision    : 1.0  initial release
// ============================================================================
module pc_pipe_buffer #(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 2,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter int               CAPTURE_EDGE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int c_OCC_W = $clog2(DEPTH+1);

    // Stage 0 is the input side, stage DEPTH-1 drives the outputs.
    logic [DEPTH-1:0]   r_v;
    logic [WIDTH-1:0]   r_d [DEPTH];
    logic [c_OCC_W-1:0] r_occ;

    logic [DEPTH-1:0]   w_mv;
    logic               w_free0;
    logic               w_take;
    logic [DEPTH-1:0]   w_v_nxt;
    logic [WIDTH-1:0]   w_d_nxt [DEPTH];
    logic [c_OCC_W-1:0] w_occ_nxt;

    // Ready ripples from the output back to the input: a stage can move
    // forward if the stage ahead is empty or is itself moving. Walking from
    // the output side inside one process keeps the chain free of
    // cross-process bit loops.
    always_comb begin : p_advance
        logic w_free_dn;
        w_mv      = '0;
        w_free_dn = out_ready;
        for (int i = DEPTH-1; i >= 0; i--) begin
            w_mv[i]   = r_v[i] & w_free_dn;
            w_free_dn = !r_v[i] | w_mv[i];
        end
        w_free0 = w_free_dn;
    end

    assign in_ready = w_free0 & ~flush;
    assign w_take   = in_valid & in_ready;

    always_comb begin : p_next
        w_v_nxt   = r_v;
        w_d_nxt   = r_d;
        w_occ_nxt = '0;
        if (flush) begin
            w_v_nxt = '0;
            w_d_nxt = '{default: RESET_VAL};
        end else begin
            // Emptying first; a refill on the same edge overrides it.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_mv[i]) begin
                    w_v_nxt[i] = 1'b0;
                end
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (w_mv[i-1]) begin
                    w_v_nxt[i] = 1'b1;
                    w_d_nxt[i] = r_d[i-1];
                end
            end
            if (w_take) begin
                w_v_nxt[0] = 1'b1;
                w_d_nxt[0] = in_data;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            w_occ_nxt = w_occ_nxt + c_OCC_W'(w_v_nxt[i]);
        end
    end

    // Only one edge flavour is elaborated; both share the same next state.
    generate
        if (CAPTURE_EDGE != 0) begin : g_negedge
            always_ff @(negedge clk) begin
                if (rst) begin
                    r_v   <= '0;
                    r_d   <= '{default: RESET_VAL};
                    r_occ <= '0;
                end else begin
                    r_v   <= w_v_nxt;
                    r_d   <= w_d_nxt;
                    r_occ <= w_occ_nxt;
                end
            end
        end else begin : g_posedge
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v   <= '0;
                    r_d   <= '{default: RESET_VAL};
                    r_occ <= '0;
                end else begin
                    r_v   <= w_v_nxt;
                    r_d   <= w_d_nxt;
                    r_occ <= w_occ_nxt;
                end
            end
        end
    endgenerate

    assign out_valid = r_v[DEPTH-1];
    assign out_data  = r_d[DEPTH-1];
    assign occupancy = r_occ;

endmodule
`default_nettype wire
